// File: rtl/pkt_tm_pkg.sv
// pkt_tm_pkg: shared parameters, descriptor layout and FSM encodings for the RX traffic manager
package pkt_tm_pkg;
    localparam int CHAN_NUMS  = 8;
    localparam int RAM_DEPTH  = 11;
    localparam int LEN_WIDTH  = 10;
    localparam int CH_W       = 3;
    localparam int DESC_W     = 24;
    localparam int LEN_LSB    = 11;
    localparam int ADDR_LSB   = 0;
    // Channel field of the header beat, in the big-endian [0:15] numbering of rx_data
    localparam int HDR_CH_MSB = 13;
    localparam int HDR_CH_LSB = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RECV = 3'b010,
        ST_DROP = 3'b100
    } state_t;

    function automatic logic [DESC_W-1:0] mk_desc(input logic [LEN_WIDTH-1:0] len,
                                                  input logic [RAM_DEPTH-1:0] addr);
        mk_desc = '0;
        mk_desc[LEN_LSB +: LEN_WIDTH]  = len;
        mk_desc[ADDR_LSB +: RAM_DEPTH] = addr;
    endfunction
endpackage

// File: rtl/pkt_rx_wptr.sv
// pkt_rx_wptr: bank of per-channel payload RAM write pointers
// Ports: clk, rst (sync, active-high); i_rd_ch -> o_rd_ptr (combinational read);
//        i_wr_en/i_wr_ch/i_wr_ptr commit port, applied on the clock edge.
module pkt_rx_wptr
    import pkt_tm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH_W-1:0]      i_rd_ch,
    output logic [RAM_DEPTH-1:0] o_rd_ptr,
    input  logic                 i_wr_en,
    input  logic [CH_W-1:0]      i_wr_ch,
    input  logic [RAM_DEPTH-1:0] i_wr_ptr
);
    logic [RAM_DEPTH-1:0] r_ptr [CHAN_NUMS];

    // A commit lands on the eof edge, so a sof one cycle later already reads the new value
    assign o_rd_ptr = r_ptr[i_rd_ch];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHAN_NUMS; i++) r_ptr[i] <= '0;
        end else if (i_wr_en) begin
            r_ptr[i_wr_ch] <= i_wr_ptr;
        end
    end
endmodule

// File: rtl/pkt_rx_tm.sv
// pkt_rx_tm: LocalLink RX demux into per-channel payload RAMs with descriptor commit/drop
// Ports: clk, rst (sync, active-high);
//        i_rx_* LocalLink receive beat (active-low framing, no back-pressure, rem ignored);
//        o_ram_* registered shared RAM write port with one-hot channel enable;
//        o_desc_* registered one-hot descriptor push, i_desc_afull per-channel FIFO almost-full;
//        o_drop_pulse one cycle per discarded frame, o_good_cnt/o_drop_cnt wrapping counters.
module pkt_rx_tm
    import pkt_tm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:15]          i_rx_data,
    input  logic                 i_rx_rem,
    input  logic                 i_rx_sof_n,
    input  logic                 i_rx_eof_n,
    input  logic                 i_rx_src_rdy_n,
    output logic [RAM_DEPTH-1:0] o_ram_waddr,
    output logic [15:0]          o_ram_din,
    output logic [CHAN_NUMS-1:0] o_ram_wren,
    output logic [DESC_W-1:0]    o_desc_din,
    output logic [CHAN_NUMS-1:0] o_desc_wren,
    input  logic [CHAN_NUMS-1:0] i_desc_afull,
    output logic                 o_drop_pulse,
    output logic [15:0]          o_good_cnt,
    output logic [15:0]          o_drop_cnt
);
    state_t               r_state, w_next;
    logic [CH_W-1:0]      r_ch, w_ch, w_hdr_ch;
    logic [RAM_DEPTH-1:0] r_start, w_start, r_waddr, w_waddr, w_rd_ptr, w_nptr;
    logic [LEN_WIDTH-1:0] r_cnt, w_cnt, w_len;
    logic                 w_valid, w_sof, w_eof, w_full, w_wr, w_commit, w_unused_rem;
    logic [1:0]           w_ndrop;
    logic [RAM_DEPTH-1:0] r_ram_waddr;
    logic [15:0]          r_ram_din, r_good_cnt, r_drop_cnt;
    logic [CHAN_NUMS-1:0] r_ram_wren, r_desc_wren;
    logic [DESC_W-1:0]    r_desc_din;
    logic                 r_drop;

    assign w_unused_rem = i_rx_rem;
    assign w_valid  = !i_rx_src_rdy_n;
    assign w_sof    = w_valid && !i_rx_sof_n;
    assign w_eof    = w_valid && !i_rx_eof_n;
    assign w_hdr_ch = i_rx_data[HDR_CH_MSB:HDR_CH_LSB];
    // 1023 words already stored: one more beat would exceed the length field
    assign w_full   = (r_cnt == {LEN_WIDTH{1'b1}});
    assign w_len    = r_cnt + LEN_WIDTH'(1);
    assign w_nptr   = r_waddr + RAM_DEPTH'(1);

    pkt_rx_wptr u_wptr (
        .clk      (clk),
        .rst      (rst),
        .i_rd_ch  (w_hdr_ch),
        .o_rd_ptr (w_rd_ptr),
        .i_wr_en  (w_commit),
        .i_wr_ch  (r_ch),
        .i_wr_ptr (w_nptr)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // w_ndrop is 2 bits because a sof inside ST_RECV can abandon the current frame
    // and reject the new one (afull or header-only) on the same beat
    always_comb begin
        w_next   = r_state;
        w_ch     = r_ch;
        w_start  = r_start;
        w_waddr  = r_waddr;
        w_cnt    = r_cnt;
        w_wr     = 1'b0;
        w_commit = 1'b0;
        w_ndrop  = 2'd0;
        if (w_sof) begin
            w_ch    = w_hdr_ch;
            w_start = w_rd_ptr;
            w_waddr = w_rd_ptr;
            w_cnt   = '0;
            w_ndrop = {1'b0, r_state == ST_RECV} + {1'b0, w_eof || i_desc_afull[w_hdr_ch]};
            w_next  = w_eof ? ST_IDLE : i_desc_afull[w_hdr_ch] ? ST_DROP : ST_RECV;
        end else if (w_eof) begin
            w_next   = ST_IDLE;
            w_wr     = (r_state == ST_RECV) && !w_full;
            w_commit = w_wr;
            w_ndrop  = {1'b0, (r_state == ST_IDLE) || ((r_state == ST_RECV) && w_full)};
        end else if (w_valid && r_state == ST_RECV) begin
            w_wr    = !w_full;
            w_next  = w_full ? ST_DROP : ST_RECV;
            w_ndrop = {1'b0, w_full};
            w_waddr = w_nptr;
            w_cnt   = w_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch        <= '0;
            r_start     <= '0;
            r_waddr     <= '0;
            r_cnt       <= '0;
            r_ram_waddr <= '0;
            r_ram_din   <= '0;
            r_ram_wren  <= '0;
            r_desc_din  <= '0;
            r_desc_wren <= '0;
            r_drop      <= 1'b0;
            r_good_cnt  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_ch        <= w_ch;
            r_start     <= w_start;
            r_waddr     <= w_waddr;
            r_cnt       <= w_cnt;
            r_ram_waddr <= w_wr ? r_waddr : '0;
            r_ram_din   <= w_wr ? i_rx_data : '0;
            r_ram_wren  <= w_wr ? CHAN_NUMS'(1) << r_ch : '0;
            r_desc_din  <= w_commit ? mk_desc(w_len, r_start) : '0;
            r_desc_wren <= w_commit ? CHAN_NUMS'(1) << r_ch : '0;
            r_drop      <= |w_ndrop;
            r_good_cnt  <= r_good_cnt + 16'(w_commit);
            r_drop_cnt  <= r_drop_cnt + 16'(w_ndrop);
        end
    end

    assign o_ram_waddr  = r_ram_waddr;
    assign o_ram_din    = r_ram_din;
    assign o_ram_wren   = r_ram_wren;
    assign o_desc_din   = r_desc_din;
    assign o_desc_wren  = r_desc_wren;
    assign o_drop_pulse = r_drop;
    assign o_good_cnt   = r_good_cnt;
    assign o_drop_cnt   = r_drop_cnt;
endmodule

// File: tb/tb_pkt_rx_tm.sv
// tb_pkt_rx_tm: table-driven frame stimulus with RAM/descriptor scoreboards for pkt_rx_tm
module tb_pkt_rx_tm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rx_data = '0;
    logic        rx_rem = 1'b0;
    logic        sof_n = 1'b1, eof_n = 1'b1, src_rdy_n = 1'b1;
    logic [7:0]  afull = '0;
    logic [10:0] o_ram_waddr;
    logic [15:0] o_ram_din, o_good_cnt, o_drop_cnt;
    logic [7:0]  o_ram_wren, o_desc_wren;
    logic [23:0] o_desc_din;
    logic        o_drop_pulse;

    typedef struct {logic [7:0] wren; logic [10:0] addr; logic [15:0] din;} ram_t;
    typedef struct {logic [7:0] wren; logic [23:0] din;} desc_t;
    typedef struct {int ch; int n; bit af; bit ok; logic [23:0] desc;} vec_t;

    ram_t        ram_q[$];
    desc_t       desc_q[$];
    ram_t        re;
    desc_t       de;
    logic [10:0] m_ptr [8];
    int          checks = 0, errs = 0, pulses = 0, m_good = 0, m_drop = 0;
    vec_t        tbl [12];

    pkt_rx_tm dut (
        .clk            (clk),
        .rst            (rst),
        .i_rx_data      (rx_data),
        .i_rx_rem       (rx_rem),
        .i_rx_sof_n     (sof_n),
        .i_rx_eof_n     (eof_n),
        .i_rx_src_rdy_n (src_rdy_n),
        .o_ram_waddr    (o_ram_waddr),
        .o_ram_din      (o_ram_din),
        .o_ram_wren     (o_ram_wren),
        .o_desc_din     (o_desc_din),
        .o_desc_wren    (o_desc_wren),
        .i_desc_afull   (afull),
        .o_drop_pulse   (o_drop_pulse),
        .o_good_cnt     (o_good_cnt),
        .o_drop_cnt     (o_drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_ram_wren != 0) begin
            checks++;
            if (ram_q.size() == 0) begin
                errs++;
                $display("FAIL ram_extra got wren=%h addr=%0d din=%h, none expected", o_ram_wren, o_ram_waddr, o_ram_din);
            end else begin
                re = ram_q.pop_front();
                if (o_ram_wren !== re.wren || o_ram_waddr !== re.addr || o_ram_din !== re.din) begin
                    errs++;
                    $display("FAIL ram_write got wren=%h addr=%0d din=%h want wren=%h addr=%0d din=%h",
                             o_ram_wren, o_ram_waddr, o_ram_din, re.wren, re.addr, re.din);
                end
            end
        end
        if (o_desc_wren != 0) begin
            checks++;
            if (desc_q.size() == 0) begin
                errs++;
                $display("FAIL desc_extra got wren=%h din=%h, none expected", o_desc_wren, o_desc_din);
            end else begin
                de = desc_q.pop_front();
                if (o_desc_wren !== de.wren || o_desc_din !== de.din) begin
                    errs++;
                    $display("FAIL desc_write got wren=%h din=%h want wren=%h din=%h", o_desc_wren, o_desc_din, de.wren, de.din);
                end
            end
        end
        if (o_drop_pulse) pulses++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic beat(input bit s, input bit e, input logic [15:0] d, input logic [7:0] af);
        @(posedge clk);
        #1;
        src_rdy_n = 1'b0;
        sof_n     = !s;
        eof_n     = !e;
        rx_data   = d;
        afull     = af;
    endtask

    // Invalid beats carry junk framing to show they are ignored
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            src_rdy_n = 1'b1;
            sof_n     = 1'($urandom_range(0, 1));
            eof_n     = 1'($urandom_range(0, 1));
            rx_data   = 16'($urandom);
            afull     = '0;
        end
    endtask

    task automatic push_wr(input int ch, input logic [10:0] addr, input logic [15:0] d);
        ram_t t;
        t.wren = 8'd1 << ch;
        t.addr = addr;
        t.din  = d;
        ram_q.push_back(t);
    endtask

    task automatic push_desc(input int ch, input logic [23:0] d);
        desc_t t;
        t.wren = 8'd1 << ch;
        t.din  = d;
        desc_q.push_back(t);
    endtask

    // n payload words after the header; the eof rides on the last payload word (or the header if n==0)
    task automatic send_frame(input int ch, input int n, input bit af, input bit ok, input logic [23:0] desc);
        logic [15:0] d;
        beat(1'b1, n == 0, {13'($urandom), 3'(ch)}, af ? 8'd1 << ch : 8'd0);
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            beat(1'b0, i == n - 1, d, 8'd0);
            if (!af && i < 1023) push_wr(ch, m_ptr[ch] + 11'(i), d);
        end
        if (ok) begin
            push_desc(ch, desc);
            m_ptr[ch] += 11'(n);
            m_good++;
        end else begin
            m_drop++;
        end
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, "_good"}, o_good_cnt, m_good);
        chk({nm, "_drop"}, o_drop_cnt, m_drop);
        chk({nm, "_pulses"}, pulses, m_drop);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ram"}, {o_ram_waddr, o_ram_din}, 0);
        chk({nm, "_en"}, {o_ram_wren, o_desc_wren, o_drop_pulse}, 0);
        chk({nm, "_desc"}, o_desc_din, 0);
        chk({nm, "_cnt"}, {o_good_cnt, o_drop_cnt}, 0);
    endtask

    initial begin
        logic [15:0] d;
        for (int i = 0; i < 8; i++) m_ptr[i] = '0;
        tbl[0]  = '{3, 4,    0, 1, 24'h002000};
        tbl[1]  = '{3, 2,    0, 1, 24'h001004};
        tbl[2]  = '{0, 2,    0, 1, 24'h001000};
        tbl[3]  = '{1, 1024, 0, 0, 24'h000000};
        tbl[4]  = '{1, 1025, 0, 0, 24'h000000};
        tbl[5]  = '{1, 1,    0, 1, 24'h000800};
        tbl[6]  = '{5, 3,    1, 0, 24'h000000};
        tbl[7]  = '{5, 1023, 0, 1, 24'h1FF800};
        tbl[8]  = '{2, 1023, 0, 1, 24'h1FF800};
        tbl[9]  = '{2, 1023, 0, 1, 24'h1FFBFF};
        tbl[10] = '{2, 4,    0, 1, 24'h0027FE};
        tbl[11] = '{2, 1,    0, 1, 24'h000802};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 12; k++)
            send_frame(tbl[k].ch, tbl[k].n, tbl[k].af, tbl[k].ok, tbl[k].desc);
        idle(3);
        @(negedge clk);
        chk_counts("table");

        // sof in the middle of a frame abandons it and restarts at the same pointer
        beat(1'b1, 1'b0, 16'h0004, 8'd0);
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom);
            beat(1'b0, 1'b0, d, 8'd0);
            push_wr(4, m_ptr[4] + 11'(i), d);
        end
        m_drop++;
        send_frame(4, 3, 0, 1, 24'h001800);
        idle(2);
        beat(1'b0, 1'b1, 16'($urandom), 8'd0);
        m_drop++;
        idle(1);
        send_frame(6, 0, 0, 0, 24'h000000);
        // frame with invalid beats interleaved
        beat(1'b1, 1'b0, 16'h0006, 8'd0);
        idle(1);
        d = 16'($urandom);
        beat(1'b0, 1'b0, d, 8'd0);
        push_wr(6, 11'd0, d);
        idle(2);
        d = 16'($urandom);
        beat(1'b0, 1'b1, d, 8'd0);
        push_wr(6, 11'd1, d);
        push_desc(6, 24'h001000);
        m_good++;
        idle(3);
        @(negedge clk);
        chk_counts("proto");

        // reset in the middle of a frame
        beat(1'b1, 1'b0, 16'h0007, 8'd0);
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom);
            beat(1'b0, 1'b0, d, 8'd0);
            push_wr(7, 11'(i), d);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        src_rdy_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        m_good = 0;
        m_drop = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) m_ptr[i] = '0;
        send_frame(3, 1, 0, 1, 24'h000800);
        send_frame(7, 2, 0, 1, 24'h001000);
        idle(4);
        @(negedge clk);
        chk_counts("after_rst");
        chk("ram_q_left", ram_q.size(), 0);
        chk("desc_q_left", desc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
